// File: rtl/tensor_core_scheduler.sv
// Tensor core job scheduler.
//
// Arbitrates between two requesters with a round-robin pointer. It forwards the
// granted operand matrices to a tensor core, pulses write-enable and then start,
// and waits for completion or a timeout. The result, or a zeroed error response,
// is then held on the response handshake until it is taken.
//
// Ports:
//   clock_in, reset_n_in          clock; asynchronous active-low reset
//   request_valid/ready[1:0]      per-requester job handshake (ready only in IDLE)
//   request_input1/2[1:0]         per-requester operand matrices A and B
//   response_valid/ready          result handshake
//   response_id/error/matrix      requester index, timeout flag, result matrix
//   core_write_enable, core_start one-cycle pulses toward the tensor core
//   core_input1/2                 operands held stable for the whole job
//   core_output, core_done        tensor core result and completion flag
//   busy                          high whenever the scheduler is not idle
//
// Matrices are [row][col] of signed 8-bit elements and pass through unmodified.

module tensor_core_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic                            clock_in,
  input  logic                            reset_n_in,
  input  logic [1:0]                      request_valid,
  output logic [1:0]                      request_ready,
  input  logic signed [1:0][3:0][3:0][7:0] request_input1,
  input  logic signed [1:0][3:0][3:0][7:0] request_input2,
  output logic                            response_valid,
  input  logic                            response_ready,
  output logic                            response_id,
  output logic                            response_error,
  output logic signed [3:0][3:0][7:0]     response_matrix,
  output logic                            core_write_enable,
  output logic                            core_start,
  output logic signed [3:0][3:0][7:0]     core_input1,
  output logic signed [3:0][3:0][7:0]     core_input2,
  input  logic signed [3:0][3:0][7:0]     core_output,
  input  logic                            core_done,
  output logic                            busy
);

  // Wide enough to hold TIMEOUT_CYCLES itself.
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWait,
    StRespond
  } state_e;

  state_e state_q, state_d;

  logic                        ptr_q, ptr_d;
  logic                        id_q;
  logic [CntW-1:0]             cnt_q;
  logic [CntW-1:0]             cnt_inc;
  logic                        timeout_hit;
  logic signed [3:0][3:0][7:0] core_a_q;
  logic signed [3:0][3:0][7:0] core_b_q;
  logic signed [3:0][3:0][7:0] resp_mat_q;
  logic                        resp_err_q;

  logic grant_valid;
  logic grant_idx;
  logic load_req;
  logic clr_cnt;
  logic inc_cnt;
  logic capture_done;
  logic capture_timeout;

  // Round-robin choice: the requester under the pointer wins a tie.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr_q;
    if (request_valid[ptr_q]) begin
      grant_valid = 1'b1;
      grant_idx   = ptr_q;
    end else if (request_valid[~ptr_q]) begin
      grant_valid = 1'b1;
      grant_idx   = ~ptr_q;
    end
  end

  // Ready is also gated by reset so every output reads zero while reset is held.
  always_comb begin
    request_ready = 2'b00;
    if (state_q == StIdle && grant_valid && reset_n_in) begin
      request_ready[grant_idx] = 1'b1;
    end
  end

  assign cnt_inc     = cnt_q + CntW'(1);
  assign timeout_hit = (cnt_inc == CntW'(TIMEOUT_CYCLES));

  // Next-state and datapath control.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    load_req        = 1'b0;
    clr_cnt         = 1'b0;
    inc_cnt         = 1'b0;
    capture_done    = 1'b0;
    capture_timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          load_req = 1'b1;
          ptr_d    = ~grant_idx;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        state_d = StStart;
      end
      StStart: begin
        clr_cnt = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        inc_cnt = 1'b1;
        // A completion on the same edge as the timeout still counts as success.
        if (core_done) begin
          capture_done = 1'b1;
          state_d      = StRespond;
        end else if (timeout_hit) begin
          capture_timeout = 1'b1;
          state_d         = StRespond;
        end
      end
      StRespond: begin
        if (response_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      id_q       <= 1'b0;
      cnt_q      <= '0;
      core_a_q   <= '0;
      core_b_q   <= '0;
      resp_mat_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      // Operands change only on acceptance, so they stay put through RESPOND.
      if (load_req) begin
        core_a_q <= request_input1[grant_idx];
        core_b_q <= request_input2[grant_idx];
        id_q     <= grant_idx;
      end
      if (clr_cnt) begin
        cnt_q <= '0;
      end else if (inc_cnt) begin
        cnt_q <= cnt_inc;
      end
      if (capture_done) begin
        resp_mat_q <= core_output;
        resp_err_q <= 1'b0;
      end else if (capture_timeout) begin
        resp_mat_q <= '0;
        resp_err_q <= 1'b1;
      end
    end
  end

  assign busy              = (state_q != StIdle);
  assign core_write_enable = (state_q == StLoad);
  assign core_start        = (state_q == StStart);
  assign response_valid    = (state_q == StRespond);
  assign response_id       = id_q;
  assign response_error    = resp_err_q;
  assign response_matrix   = resp_mat_q;
  assign core_input1       = core_a_q;
  assign core_input2       = core_b_q;

  a_ready_onehot: assert property (
    @(posedge clock_in) disable iff (!reset_n_in) $onehot0(request_ready)
  );

  a_load_then_start: assert property (
    @(posedge clock_in) disable iff (!reset_n_in)
    core_write_enable |=> (core_start && !core_write_enable)
  );

  a_resp_stable: assert property (
    @(posedge clock_in) disable iff (!reset_n_in)
    (response_valid && !response_ready) |=>
      (response_valid && $stable(response_matrix) && $stable(response_id) &&
       $stable(response_error))
  );

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// Self-checking bench for tensor_core_scheduler: a vector table of jobs, a scoreboard
// queue of expected responses, a behavioural tensor core (wrapping 8-bit matmul) and
// hand-written sequences for backpressure, stale done and reset mid-job.
module tb_tensor_core_scheduler;

  localparam int unsigned T = 32;

  typedef logic [3:0][3:0][7:0] mat_t;

  typedef struct {
    logic [1:0] valid;
    mat_t       a0, b0, a1, b1;
    int         delay;     // core_done on WAIT edge delay+1; negative = never
    logic       exp_id;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic id;
    logic err;
    mat_t mat;
  } exp_t;

  logic                       clock_in = 1'b0;
  logic                       reset_n_in;
  logic [1:0]                 request_valid;
  logic [1:0]                 request_ready;
  logic [1:0][3:0][3:0][7:0]  request_input1;
  logic [1:0][3:0][3:0][7:0]  request_input2;
  logic                       response_valid;
  logic                       response_ready;
  logic                       response_id;
  logic                       response_error;
  mat_t                       response_matrix;
  logic                       core_write_enable;
  logic                       core_start;
  mat_t                       core_input1;
  mat_t                       core_input2;
  mat_t                       core_output;
  logic                       core_done;
  logic                       busy;

  wire [391:0] all_out = {request_ready, response_valid, response_id, response_error,
                          response_matrix, core_write_enable, core_start, core_input1,
                          core_input2, busy};

  tensor_core_scheduler #(.TIMEOUT_CYCLES(T)) dut (
    .clock_in          (clock_in),
    .reset_n_in        (reset_n_in),
    .request_valid     (request_valid),
    .request_ready     (request_ready),
    .request_input1    (request_input1),
    .request_input2    (request_input2),
    .response_valid    (response_valid),
    .response_ready    (response_ready),
    .response_id       (response_id),
    .response_error    (response_error),
    .response_matrix   (response_matrix),
    .core_write_enable (core_write_enable),
    .core_start        (core_start),
    .core_input1       (core_input1),
    .core_input2       (core_input2),
    .core_output       (core_output),
    .core_done         (core_done),
    .busy              (busy)
  );

  always #5 clock_in = ~clock_in;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   hs_cnt = 0;
  int   resp_cnt = 0;
  int   we_cnt = 0;
  int   st_cnt = 0;
  int   core_cnt = -1;
  int   core_delay = 0;
  int   cur_lat = 0;
  bit   lat_pending = 0;
  bit   stale_mode = 0;
  logic cur_exp_id = 1'b0;
  logic cur_err = 1'b0;
  exp_t exp_q[$];
  vec_t vecs[9];

  function automatic mat_t mat_mul(mat_t a, mat_t b);
    mat_t r;
    int   acc;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) begin
          acc += int'($signed(a[i][k])) * int'($signed(b[k][j]));
        end
        r[i][j] = acc[7:0];
      end
    end
    return r;
  endfunction

  function automatic mat_t mat_fill(logic [7:0] v);
    mat_t r;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) r[i][j] = v;
    return r;
  endfunction

  function automatic mat_t mat_ident();
    mat_t r;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) r[i][j] = (i == j) ? 8'd1 : 8'd0;
    return r;
  endfunction

  function automatic mat_t mat_rand();
    mat_t r;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) r[i][j] = 8'($urandom);
    return r;
  endfunction

  task automatic check(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Samples DUT outputs and feeds the scoreboard.
  task automatic monitor();
    exp_t e;
    if (!reset_n_in) begin
      exp_q.delete();
      lat_pending = 0;
      return;
    end
    if (core_write_enable) we_cnt++;
    if (core_start) st_cnt++;
    if (request_ready != 2'b00) begin
      check("ready_onehot", $countones(request_ready), 1);
      for (int i = 0; i < 2; i++) begin
        if (request_valid[i] && request_ready[i]) begin
          check("grant_id", i, cur_exp_id);
          e.id  = 1'(i);
          e.err = cur_err;
          e.mat = cur_err ? '0 : mat_mul(request_input1[i], request_input2[i]);
          exp_q.push_back(e);
          hs_cnt++;
          hs_cyc      = cyc;
          lat_pending = 1;
        end
      end
    end
    if (response_valid && lat_pending) begin
      check("latency", cyc - hs_cyc - 1, cur_lat);
      lat_pending = 0;
    end
    if (response_valid && response_ready) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("resp_id", response_id, e.id);
        check("resp_err", response_error, e.err);
        check("resp_matrix", response_matrix, e.mat);
      end
      resp_cnt++;
    end
  endtask

  // Behavioural tensor core; in stale mode it holds done high with junk data
  // everywhere except the genuine completion.
  task automatic core_model();
    core_done = 1'b0;
    if (core_start) begin
      core_cnt = core_delay;
      if (stale_mode) begin
        core_done   = 1'b1;
        core_output = mat_fill(8'h7e);
      end
    end else if (core_cnt == 0) begin
      core_done   = 1'b1;
      core_output = mat_mul(core_input1, core_input2);
      core_cnt    = -1;
    end else if (core_cnt > 0) begin
      core_cnt--;
    end else if (stale_mode) begin
      core_done   = 1'b1;
      core_output = mat_fill(8'h7e);
    end
  endtask

  // One cycle: sample at negedge, return 1 time unit after the next posedge.
  task automatic tick();
    @(negedge clock_in);
    cyc++;
    monitor();
    core_model();
    @(posedge clock_in);
    #1;
  endtask

  task automatic wait_resp(int target, int limit);
    for (int k = 0; k < limit && resp_cnt < target; k++) tick();
    check("resp_seen", resp_cnt, target);
  endtask

  task automatic run_vec(vec_t v);
    request_input1[0] = v.a0;
    request_input2[0] = v.b0;
    request_input1[1] = v.a1;
    request_input2[1] = v.b1;
    request_valid     = v.valid;
    core_delay        = v.delay;
    cur_exp_id        = v.exp_id;
    cur_err           = v.exp_err;
    cur_lat           = (v.delay < 0 || v.delay >= int'(T)) ? 2 + int'(T) : 3 + v.delay;
    wait_resp(resp_cnt + 1, 100);
  endtask

  task automatic init_vecs();
    for (int i = 0; i < 9; i++) begin
      vecs[i].a0 = mat_rand();
      vecs[i].b0 = mat_rand();
      vecs[i].a1 = mat_rand();
      vecs[i].b1 = mat_rand();
      vecs[i].exp_err = 1'b0;
    end
    vecs[0].a0 = mat_ident();
    vecs[0].b0 = mat_fill(8'd2);
    vecs[0].valid = 2'b01; vecs[0].delay = 0;      vecs[0].exp_id = 1'b0;
    vecs[1].valid = 2'b10; vecs[1].delay = 3;      vecs[1].exp_id = 1'b1;
    vecs[2].valid = 2'b11; vecs[2].delay = 0;      vecs[2].exp_id = 1'b0;
    vecs[3].valid = 2'b11; vecs[3].delay = 1;      vecs[3].exp_id = 1'b1;
    vecs[4].valid = 2'b11; vecs[4].delay = 2;      vecs[4].exp_id = 1'b0;
    vecs[5].valid = 2'b11; vecs[5].delay = 5;      vecs[5].exp_id = 1'b1;
    vecs[6].valid = 2'b01; vecs[6].delay = -1;     vecs[6].exp_id = 1'b0;
    vecs[6].exp_err = 1'b1;
    // Done on the very edge the timeout would fire: success wins.
    vecs[7].valid = 2'b01; vecs[7].delay = T - 1;  vecs[7].exp_id = 1'b0;
    // Done one edge too late: already responding with an error.
    vecs[8].valid = 2'b10; vecs[8].delay = T;      vecs[8].exp_id = 1'b1;
    vecs[8].exp_err = 1'b1;
  endtask

  initial begin
    mat_t a, b, expm;
    vec_t v;
    int   target;

    reset_n_in     = 1'b0;
    request_valid  = 2'b00;
    request_input1 = '0;
    request_input2 = '0;
    response_ready = 1'b1;
    core_output    = '0;
    core_done      = 1'b0;
    init_vecs();

    repeat (2) @(posedge clock_in);
    #1;
    check("reset_outputs", all_out, 0);
    reset_n_in = 1'b1;
    tick();
    check("idle_busy", busy, 0);
    check("idle_ready", request_ready, 0);

    foreach (vecs[i]) run_vec(vecs[i]);
    request_valid = 2'b00;
    tick();

    // Backpressure: response held for 10 cycles while both requesters wait.
    a = mat_rand();
    b = mat_rand();
    expm = mat_mul(a, b);
    request_input1[0] = a;
    request_input2[0] = b;
    request_valid  = 2'b01;
    response_ready = 1'b0;
    core_delay     = 0;
    cur_exp_id     = 1'b0;
    cur_err        = 1'b0;
    cur_lat        = 3;
    for (int k = 0; k < 20 && !response_valid; k++) tick();
    check("bp_valid_seen", response_valid, 1);
    request_valid = 2'b11;
    repeat (10) begin
      tick();
      check("bp_valid", response_valid, 1);
      check("bp_id", response_id, 0);
      check("bp_err", response_error, 0);
      check("bp_matrix", response_matrix, expm);
      check("bp_ready_low", request_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_core_in1", core_input1, a);
      check("bp_core_in2", core_input2, b);
    end
    response_ready = 1'b1;
    request_valid  = 2'b00;
    wait_resp(resp_cnt + 1, 5);
    tick();
    check("bp_idle", busy, 0);

    // Stale done: core_done high with junk in IDLE, LOAD and START.
    stale_mode = 1;
    tick();
    tick();
    check("stale_idle_busy", busy, 0);
    check("stale_idle_valid", response_valid, 0);
    v = vecs[1];
    v.delay = 0;
    run_vec(v);
    stale_mode    = 0;
    request_valid = 2'b00;
    tick();

    // Reset while waiting on the core, with both requesters asserting.
    request_input1[0] = mat_rand();
    request_input2[0] = mat_rand();
    request_valid = 2'b01;
    core_delay    = -1;
    cur_exp_id    = 1'b0;
    cur_err       = 1'b1;
    cur_lat       = 2 + int'(T);
    repeat (6) tick();
    check("wait_busy", busy, 1);
    check("wait_no_resp", response_valid, 0);
    request_valid = 2'b11;
    #2;
    reset_n_in = 1'b0;
    #1;
    check("async_reset_outputs", all_out, 0);
    tick();
    tick();
    check("held_reset_outputs", all_out, 0);
    a = mat_rand();
    b = mat_rand();
    request_input1[0] = a;
    request_input2[0] = b;
    request_input1[1] = mat_rand();
    request_input2[1] = mat_rand();
    core_delay = 0;
    cur_exp_id = 1'b0;
    cur_err    = 1'b0;
    cur_lat    = 3;
    reset_n_in = 1'b1;
    #1;
    check("post_reset_tie", request_ready, 2'b01);
    target = resp_cnt + 1;
    tick();
    request_valid = 2'b00;
    wait_resp(target, 20);
    tick();

    check("we_pulses", we_cnt, hs_cnt);
    check("start_pulses", st_cnt, hs_cnt);
    check("queue_empty", exp_q.size(), 0);
    check("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
